// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Core-side data-memory bus bundle for dmem_responder.
//               master : driven by the core / bench (address, store data,
//                        write enable, switch inputs)
//               slave  : driven by dmem_responder (read data, valid, LED
//                        register, sticky error flag)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic [31:0] d_addr;   // word address
    logic [31:0] wdata;    // store data
    logic        wea;      // write enable, sampled every cycle
    logic [7:0]  sw;       // switch inputs
    logic [31:0] rdata;    // read data
    logic        rvalid;   // rdata reflects a post-reset sample
    logic [7:0]  led_out;  // LED register
    logic        err;      // sticky illegal-access flag

    modport master (
        output d_addr, wdata, wea, sw,
        input  rdata, rvalid, led_out, err
    );

    modport slave (
        input  d_addr, wdata, wea, sw,
        output rdata, rvalid, led_out, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data RAM plus a small MMIO page (LED register,
//               free-running cycle counter, switch inputs). Every cycle the
//               address is sampled and its data returned RD_LAT cycles later;
//               writes take effect at the edge where wea is high.
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - dmem_responder_if.slave (d_addr, wdata, wea, sw in;
//                      rdata, rvalid, led_out, err out)
// Parameters  : DEPTH  - number of 32-bit RAM words (>= 2)
//               RD_LAT - read latency in cycles, 1..4
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_responder_if.slave bus
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [31:0] c_ADDR_LED = 32'hFFFF_FF00;
    localparam logic [31:0] c_ADDR_CNT = 32'hFFFF_FF04;
    localparam logic [31:0] c_ADDR_SW  = 32'hFFFF_FF08;

    // ------------------------------------------------------------------
    // Address decode (full 32-bit compares for MMIO)
    // ------------------------------------------------------------------
    logic            w_is_ram;
    logic            w_is_led;
    logic            w_is_cnt;
    logic            w_is_sw;
    logic            w_illegal;
    logic [c_AW-1:0] w_idx;

    assign w_is_ram  = (bus.d_addr < 32'(DEPTH));
    assign w_is_led  = (bus.d_addr == c_ADDR_LED);
    assign w_is_cnt  = (bus.d_addr == c_ADDR_CNT);
    assign w_is_sw   = (bus.d_addr == c_ADDR_SW);
    assign w_illegal = !(w_is_ram || w_is_led || w_is_cnt || w_is_sw);
    assign w_idx     = bus.d_addr[c_AW-1:0];

    // ------------------------------------------------------------------
    // RAM: not reset, read-first. Writes are suppressed during rst.
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_ram_q;

    always_ff @(posedge clk) begin
        if (!rst && bus.wea && w_is_ram) begin
            r_mem[w_idx] <= bus.wdata;
        end
        r_ram_q <= r_mem[w_idx];
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [31:0] r_cycle;
    logic [7:0]  r_led;
    logic        r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
            r_led   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (bus.wea && w_is_led) begin
                r_led <= bus.wdata[7:0];
            end
            // Every cycle is a read sample, so an illegal address alone
            // flags an error; writes to read-only MMIO also flag one.
            if (w_illegal || (bus.wea && (w_is_cnt || w_is_sw))) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline stage 1: capture the sample. MMIO values (including
    // the pre-increment counter) are taken at the sample edge; RAM data
    // comes from r_ram_q and is steered in by r_s1_ram.
    // ------------------------------------------------------------------
    logic [31:0] w_mmio_data;
    logic [31:0] r_s1_mmio;
    logic        r_s1_ram;
    logic        r_s1_vld;
    logic [31:0] w_s1_data;

    always_comb begin
        w_mmio_data = '0;
        if (w_is_led) begin
            w_mmio_data = {24'd0, r_led};
        end else if (w_is_cnt) begin
            w_mmio_data = r_cycle;
        end else if (w_is_sw) begin
            w_mmio_data = {24'd0, bus.sw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_mmio <= '0;
            r_s1_ram  <= 1'b0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_mmio <= w_mmio_data;
            r_s1_ram  <= w_is_ram;
            r_s1_vld  <= 1'b1;
        end
    end

    // Both r_s1_ram and r_s1_mmio are cleared by rst, so this is zero
    // while in reset even though r_ram_q itself is never cleared.
    assign w_s1_data = r_s1_ram ? r_ram_q : r_s1_mmio;

    // ------------------------------------------------------------------
    // Remaining RD_LAT-1 delay stages
    // ------------------------------------------------------------------
    generate
        if (RD_LAT <= 1) begin : g_lat1
            assign bus.rdata  = w_s1_data;
            assign bus.rvalid = r_s1_vld;
        end else begin : g_latn
            logic [31:0]       r_dly_data [RD_LAT-1];
            logic [RD_LAT-2:0] r_dly_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < RD_LAT-1; k++) begin
                        r_dly_data[k] <= '0;
                    end
                    r_dly_vld <= '0;
                end else begin
                    r_dly_data[0] <= w_s1_data;
                    r_dly_vld[0]  <= r_s1_vld;
                    for (int k = 1; k < RD_LAT-1; k++) begin
                        r_dly_data[k] <= r_dly_data[k-1];
                        r_dly_vld[k]  <= r_dly_vld[k-1];
                    end
                end
            end

            assign bus.rdata  = r_dly_data[RD_LAT-2];
            assign bus.rvalid = r_dly_vld[RD_LAT-2];
        end
    endgenerate

    assign bus.led_out = r_led;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder (DEPTH=1024,
//               RD_LAT=2). Inputs change 1 ns after each rising edge and
//               outputs are checked at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH  (1024),
        .RD_LAT (c_RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic we,
                         input logic [31:0] data);
        bus.d_addr = addr;
        bus.wea    = we;
        bus.wdata  = data;
    endtask

    // Present an address, let it propagate RD_LAT edges, check rdata.
    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp);
        drive(addr, 1'b0, 32'd0);
        repeat (c_RD_LAT) tick();
        check(tag, bus.rdata, exp);
    endtask

    initial begin
        drive(32'd0, 1'b0, 32'd0);
        bus.sw = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_rdata",  bus.rdata, 32'd0);
        check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_led",    {24'd0, bus.led_out}, 32'd0);
        check("rst_err",    {31'd0, bus.err}, 32'd0);

        // rvalid rises after edge RD_LAT following deassertion
        rst = 1'b0;
        tick();
        check("rvalid_edge1", {31'd0, bus.rvalid}, 32'd0);
        tick();
        check("rvalid_edge2", {31'd0, bus.rvalid}, 32'd1);

        // Seed mem[0] for the alias check later
        drive(32'd0, 1'b1, 32'h1234_5678);
        tick();

        // Write-then-read
        drive(32'd5, 1'b1, 32'hDEAD_BEEF);
        tick();
        read_chk("wr_rd_5", 32'd5, 32'hDEAD_BEEF);
        check("wr_rd_rvalid", {31'd0, bus.rvalid}, 32'd1);

        // Read-first collision on address 7
        drive(32'd7, 1'b1, 32'h0000_0001);
        tick();
        drive(32'd7, 1'b1, 32'h0000_0002);   // sample A + overwrite
        tick();
        drive(32'd7, 1'b0, 32'd0);           // sample B
        tick();
        check("collide_old", bus.rdata, 32'h0000_0001);
        tick();
        check("collide_new", bus.rdata, 32'h0000_0002);

        // LED write and switch read
        drive(32'hFFFF_FF00, 1'b1, 32'h0000_01A5);
        tick();
        check("led_load", {24'd0, bus.led_out}, 32'h0000_00A5);
        bus.sw = 8'h3C;
        read_chk("sw_read",  32'hFFFF_FF08, 32'h0000_003C);
        read_chk("led_read", 32'hFFFF_FF00, 32'h0000_00A5);
        check("err_clean", {31'd0, bus.err}, 32'd0);

        // Cycle counter wrap
        drive(32'hFFFF_FF04, 1'b0, 32'd0);
        force dut.r_cycle = 32'hFFFF_FFFE;
        #3;
        release dut.r_cycle;
        tick();                               // sample 0xFFFF_FFFE
        tick();                               // sample 0xFFFF_FFFF
        check("cnt_fffe", bus.rdata, 32'hFFFF_FFFE);
        tick();                               // sample 0x0000_0000
        check("cnt_ffff", bus.rdata, 32'hFFFF_FFFF);
        tick();
        check("cnt_wrap", bus.rdata, 32'h0000_0000);

        // Illegal access: 0x400 must not alias onto mem[0]
        drive(32'h0000_0400, 1'b1, 32'h0000_0055);
        tick();
        check("err_set", {31'd0, bus.err}, 32'd1);
        read_chk("illegal_rd", 32'h0000_0400, 32'd0);
        read_chk("mem0_intact", 32'd0, 32'h1234_5678);
        check("err_sticky", {31'd0, bus.err}, 32'd1);

        // Reset mid-stream with wea asserted on a RAM address
        drive(32'd5, 1'b0, 32'd0);
        tick();
        rst = 1'b1;
        drive(32'd5, 1'b1, 32'h0000_0BAD);
        tick();
        check("mid_rst_rdata",  bus.rdata, 32'd0);
        check("mid_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("mid_rst_led",    {24'd0, bus.led_out}, 32'd0);
        check("mid_rst_err",    {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        drive(32'd5, 1'b0, 32'd0);
        tick();
        check("post_rst_e1_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("post_rst_e1_rdata",  bus.rdata, 32'd0);
        tick();
        check("post_rst_e2_rvalid", {31'd0, bus.rvalid}, 32'd1);
        check("ram_kept_5", bus.rdata, 32'hDEAD_BEEF);
        read_chk("ram_kept_7", 32'd7, 32'h0000_0002);
        check("post_rst_err", {31'd0, bus.err}, 32'd0);

        // Reset with an LED write pending; counter restarts at 0
        rst = 1'b1;
        drive(32'hFFFF_FF00, 1'b1, 32'h0000_00FF);
        repeat (2) tick();
        rst = 1'b0;
        drive(32'hFFFF_FF04, 1'b0, 32'd0);
        tick();
        check("led_rst_ignored", {24'd0, bus.led_out}, 32'd0);
        tick();
        check("cnt_after_rst", bus.rdata, 32'd0);
        check("err_after_rst2", {31'd0, bus.err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
